ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the decoded operation and operands (aluop, alusel, reg1, reg2, w_addr, we) from the ID/EX register and produces the write-back result for the EX/MEM register.
- Its ex_* outputs also drive the ID forwarding inputs.
- Adds HI/LO forwarding and a 32-iteration radix-2 divider (DIV/DIVU) that stalls the pipeline through stall_req.

Parameters:
- DIV_ITER, 32, number of divider iterations (equals data width; fixed at 32).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- aluop  in  8  operation subtype (`EXE_*_OP`, including `EXE_DIV_OP` and `EXE_DIVU_OP`).
- alusel  in  3  result class (`EXE_RES_*`).
- reg1  in  32  operand 1 (rs or immediate).
- reg2  in  32  operand 2 (rt or immediate).
- w_addr  in  5  destination register.
- we  in  1  destination write enable.
- hi_i, lo_i  in  32 each  architectural HI/LO.
- mem_whilo, mem_hi, mem_lo  in  1/32/32  HI/LO write pending in MEM.
- wb_whilo, wb_hi, wb_lo  in  1/32/32  HI/LO write pending in WB.
- annul  in  1  flush; aborts any divide in progress.
- ex_we  out  1  write enable to EX/MEM and ID forwarding.
- ex_w_addr  out  5  destination.
- ex_w_data  out  32  result.
- ex_whilo  out  1  HI/LO write request.
- ex_hi, ex_lo  out  32 each  HI/LO values to write.
- stall_req  out  1  request to freeze PC, IF/ID and ID/EX.

Behaviour:
- Result path (ex_*) is combinational from the inputs and divider state. Only the divider is sequential.
- While rst=0: divider state=IDLE; all counters/registers zero; every output = 0.
- HI/LO forwarding, in priority order: mem_whilo, then wb_whilo, then hi_i/lo_i. The result is hi_f/lo_f.
- Logic ops: OR, AND, XOR, NOR on reg1, reg2.
- Shift ops: SLL, SRL, SRA shift reg2 by reg1[4:0].
- Move ops:
  - MFHI returns hi_f; MFLO returns lo_f.
  - MOVN/MOVZ return reg1. The condition is already applied in ID through we.
- ex_w_data is selected by alusel: LOGIC, SHIFT or MOVE. Any other alusel gives 0.
- ex_we = we. ex_w_addr = w_addr.
- MTHI: ex_whilo=1, ex_hi=reg1, ex_lo=lo_f.
- MTLO: ex_whilo=1, ex_hi=hi_f, ex_lo=reg1.
- Divider states are IDLE, BYZERO, ON, END.
- IDLE:
  - aluop is DIV/DIVU and annul=0, reg2==0: go to BYZERO, stall_req=1.
  - aluop is DIV/DIVU and annul=0, reg2!=0: latch operand magnitudes (absolute values for DIV, raw for DIVU), latch result sign flags, clear the 65-bit dividend/remainder register, go to ON, stall_req=1.
- BYZERO: quotient=0, remainder=0; go to END; stall_req=1.
- ON: one restoring step per cycle:
  - Shift {rem,quot} left by 1.
  - Trial subtract divisor from rem[32:0].
  - If the result is non-negative, keep it and set the quotient LSB.
  - Count 0..31. After step 32, go to END. stall_req=1.
- END:
  - Sign-correct: quotient negated if the operand signs differ (DIV only); remainder takes the dividend sign (DIV only).
  - ex_whilo=1, ex_hi=remainder, ex_lo=quotient, stall_req=0.
  - Next state is IDLE unconditionally.
- Latency for a non-zero divisor: stall_req is high for 33 cycles (IDLE cycle plus ON×32). The result appears in the 34th cycle. For a zero divisor: stall_req is high for 2 cycles; the result appears in the 3rd.
- Result registers hold their value until the next divide starts.
- annul=1 in any state: IDLE at the next edge; stall_req=0 combinationally in that cycle; ex_whilo=0; no HI/LO write.
- If rst is asserted mid-divide: abort immediately, all state returns to the reset values.
- Edge case 0x80000000 ÷ 0xFFFFFFFF (DIV): quotient 0x80000000, remainder 0 (wrap, no trap).
- Non-DIV ops never assert stall_req.

Test Plan:
- OR with reg1=0x0000FF00, reg2=0x00F0F0F0 -> ex_w_data=0x00F0FFF0, ex_we follows we, ex_w_addr follows w_addr, stall_req=0.
- SRA with reg2=0x80000000, reg1=4 -> 0xF8000000. SRL with the same operands -> 0x08000000.
- DIVU 0xFFFFFFFF / 2 -> stall_req high exactly 33 cycles, then ex_whilo=1, ex_lo=0x7FFFFFFF, ex_hi=1.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIV 5 / 0 -> stall_req high 2 cycles, then hi=lo=0.
- MFHI with mem_whilo=1, mem_hi=0x1234 and wb_whilo=1, wb_hi=0x5678 -> 0x1234 (MEM wins).
- Start DIV, assert annul at iteration 10 -> IDLE next edge, no ex_whilo.
- Repeat the DIV test, asserting rst=0 mid-divide -> all outputs 0; a following DIV runs the full 33-cycle stall.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: logic/shift/move results, HI/LO
// forwarding, and a multi-cycle restoring divider that stalls the pipeline.
//
// state  | meaning
// IDLE   | no divide running; a DIV/DIVU in ID/EX starts one
// BYZERO | divisor was zero; result forced to 0/0
// ON     | one restoring iteration per cycle
// END    | sign-corrected result presented on ex_hi/ex_lo for one cycle
module ex_stage #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop,
    input  logic [2:0]  alusel,
    input  logic [31:0] reg1,
    input  logic [31:0] reg2,
    input  logic [4:0]  w_addr,
    input  logic        we,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        mem_whilo,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic        wb_whilo,
    input  logic [31:0] wb_hi,
    input  logic [31:0] wb_lo,
    input  logic        annul,
    output logic        ex_we,
    output logic [4:0]  ex_w_addr,
    output logic [31:0] ex_w_data,
    output logic        ex_whilo,
    output logic [31:0] ex_hi,
    output logic [31:0] ex_lo,
    output logic        stall_req
);

    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_MOVZ_OP = 8'b0000_1010;
    localparam logic [7:0] EXE_MOVN_OP = 8'b0000_1011;
    localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP = 8'b0001_0011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} div_state_t;

    div_state_t  state, state_nxt;
    logic [64:0] div_reg;
    logic [31:0] divisor;
    logic [4:0]  cnt;
    logic        sign_q, sign_r;
    logic        div_stall;

    logic        is_div, neg1, neg2;
    logic [31:0] mag1, mag2;
    logic [64:0] shifted;
    logic [32:0] trial;
    logic [31:0] quot_fix, rem_fix;
    logic [31:0] hi_f, lo_f;
    logic [31:0] logic_out, shift_out, move_out;

    assign is_div = (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
    assign neg1   = (aluop == EXE_DIV_OP) && reg1[31];
    assign neg2   = (aluop == EXE_DIV_OP) && reg2[31];
    assign mag1   = neg1 ? -reg1 : reg1;
    assign mag2   = neg2 ? -reg2 : reg2;

    // {rem, quot} shifted left, then trial-subtract the divisor from the upper 33 bits
    assign shifted  = div_reg << 1;
    assign trial    = shifted[64:32] - {1'b0, divisor};
    assign quot_fix = sign_q ? -div_reg[31:0] : div_reg[31:0];
    assign rem_fix  = sign_r ? -div_reg[63:32] : div_reg[63:32];

    assign hi_f = mem_whilo ? mem_hi : (wb_whilo ? wb_hi : hi_i);
    assign lo_f = mem_whilo ? mem_lo : (wb_whilo ? wb_lo : lo_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            div_reg <= '0;
            divisor <= '0;
            cnt     <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (is_div && !annul && reg2 != 32'd0) begin
                        div_reg <= {33'd0, mag1};
                        divisor <= mag2;
                        sign_q  <= neg1 ^ neg2;
                        sign_r  <= neg1;
                        cnt     <= '0;
                    end
                end
                S_BYZERO: begin
                    div_reg <= '0;
                    sign_q  <= 1'b0;
                    sign_r  <= 1'b0;
                end
                S_ON: begin
                    if (!trial[32]) div_reg <= {trial, shifted[31:0] | 32'd1};
                    else            div_reg <= shifted;
                    cnt <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        div_stall = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_div) begin
                    div_stall = 1'b1;
                    state_nxt = (reg2 == 32'd0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                div_stall = 1'b1;
                state_nxt = S_END;
            end
            S_ON: begin
                div_stall = 1'b1;
                if (cnt == 5'(DIV_ITER - 1)) state_nxt = S_END;
            end
            S_END: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (annul) begin
            state_nxt = S_IDLE;
            div_stall = 1'b0;
        end
    end

    always_comb begin
        logic_out = '0;
        shift_out = '0;
        move_out  = '0;
        case (aluop)
            EXE_OR_OP:  logic_out = reg1 | reg2;
            EXE_AND_OP: logic_out = reg1 & reg2;
            EXE_XOR_OP: logic_out = reg1 ^ reg2;
            EXE_NOR_OP: logic_out = ~(reg1 | reg2);
            default: ;
        endcase
        case (aluop)
            EXE_SLL_OP: shift_out = reg2 << reg1[4:0];
            EXE_SRL_OP: shift_out = reg2 >> reg1[4:0];
            EXE_SRA_OP: shift_out = $signed(reg2) >>> reg1[4:0];
            default: ;
        endcase
        case (aluop)
            EXE_MFHI_OP: move_out = hi_f;
            EXE_MFLO_OP: move_out = lo_f;
            EXE_MOVN_OP, EXE_MOVZ_OP: move_out = reg1;
            default: ;
        endcase
    end

    always_comb begin
        ex_we     = 1'b0;
        ex_w_addr = '0;
        ex_w_data = '0;
        ex_whilo  = 1'b0;
        ex_hi     = '0;
        ex_lo     = '0;
        stall_req = 1'b0;
        if (rst) begin
            ex_we     = we;
            ex_w_addr = w_addr;
            stall_req = div_stall;
            case (alusel)
                EXE_RES_LOGIC: ex_w_data = logic_out;
                EXE_RES_SHIFT: ex_w_data = shift_out;
                EXE_RES_MOVE:  ex_w_data = move_out;
                default: ;
            endcase
            if (state == S_END) begin
                ex_whilo = 1'b1;
                ex_hi    = rem_fix;
                ex_lo    = quot_fix;
            end else if (aluop == EXE_MTHI_OP) begin
                ex_whilo = 1'b1;
                ex_hi    = reg1;
                ex_lo    = lo_f;
            end else if (aluop == EXE_MTLO_OP) begin
                ex_whilo = 1'b1;
                ex_hi    = hi_f;
                ex_lo    = reg1;
            end
            // a flushed instruction must never reach HI/LO
            if (annul) begin
                ex_whilo = 1'b0;
                ex_hi    = '0;
                ex_lo    = '0;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: a cycle-level reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_ex_stage;

    localparam logic [7:0] OP_NOP  = 8'b0000_0000;
    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_MOVZ = 8'b0000_1010;
    localparam logic [7:0] OP_MOVN = 8'b0000_1011;
    localparam logic [7:0] OP_MFHI = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO = 8'b0001_0011;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  aluop = OP_OR;
    logic [2:0]  alusel = SEL_LOGIC;
    logic [31:0] reg1 = 32'h1111_0000, reg2 = 32'h0000_2222;
    logic [4:0]  w_addr = 5'd5;
    logic        we = 1'b1;
    logic [31:0] hi_i = 32'h0000_AAAA, lo_i = 32'h0000_BBBB;
    logic        mem_whilo = 1'b0, wb_whilo = 1'b0;
    logic [31:0] mem_hi = '0, mem_lo = '0, wb_hi = '0, wb_lo = '0;
    logic        annul = 1'b0;
    logic        ex_we, ex_whilo, stall_req;
    logic [4:0]  ex_w_addr;
    logic [31:0] ex_w_data, ex_hi, ex_lo;

    int n_checks = 0;
    int n_fail = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .aluop(aluop), .alusel(alusel),
        .reg1(reg1), .reg2(reg2), .w_addr(w_addr), .we(we),
        .hi_i(hi_i), .lo_i(lo_i),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .annul(annul),
        .ex_we(ex_we), .ex_w_addr(ex_w_addr), .ex_w_data(ex_w_data),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Reference quotient/remainder from magnitudes, avoiding signed-overflow traps
    function automatic void div_ref(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        logic na, nb;
        logic [31:0] ma, mb, uq, ur;
        if (b == 32'd0) begin
            q = '0;
            r = '0;
        end else begin
            na = (op == OP_DIV) && a[31];
            nb = (op == OP_DIV) && b[31];
            ma = na ? (32'd0 - a) : a;
            mb = nb ? (32'd0 - b) : b;
            uq = ma / mb;
            ur = ma % mb;
            q  = (na != nb) ? (32'd0 - uq) : uq;
            r  = na ? (32'd0 - ur) : ur;
        end
    endfunction

    function automatic logic [31:0] exp_data(input logic [7:0] op, input logic [2:0] sel,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] hf, input logic [31:0] lf);
        logic [4:0] sh;
        sh = a[4:0];
        if (sel == SEL_LOGIC) begin
            if (op == OP_OR)  return a | b;
            if (op == OP_AND) return a & b;
            if (op == OP_XOR) return a ^ b;
            if (op == OP_NOR) return ~(a | b);
        end else if (sel == SEL_SHIFT) begin
            if (op == OP_SLL) return b << sh;
            if (op == OP_SRL) return b >> sh;
            if (op == OP_SRA) return (b >> sh) | ({32{b[31]}} & ~(32'hFFFF_FFFF >> sh));
        end else if (sel == SEL_MOVE) begin
            if (op == OP_MFHI) return hf;
            if (op == OP_MFLO) return lf;
            if (op == OP_MOVN || op == OP_MOVZ) return a;
        end
        return 32'd0;
    endfunction

    // phase: 0 = no divide; k = k-th cycle of the current divide; result at len+1
    int          phase = 0;
    int          div_len = 0;
    logic [31:0] mq = '0, mr = '0;

    always @(posedge clk) begin
        if (!rst || annul) begin
            phase = 0;
        end else if (phase == 0) begin
            if (is_div_op(aluop)) begin
                div_ref(aluop, reg1, reg2, mq, mr);
                div_len = (reg2 == 32'd0) ? 2 : 33;
                phase = 2;
            end
        end else if (phase == div_len + 1) begin
            phase = 0;
        end else begin
            phase++;
        end
    end

    always @(negedge clk) begin
        logic        e_we, e_whilo, e_stall;
        logic [4:0]  e_addr;
        logic [31:0] e_data, e_hi, e_lo, hf, lf;
        e_we = 0; e_addr = 0; e_data = 0; e_whilo = 0; e_hi = 0; e_lo = 0; e_stall = 0;
        hf = mem_whilo ? mem_hi : (wb_whilo ? wb_hi : hi_i);
        lf = mem_whilo ? mem_lo : (wb_whilo ? wb_lo : lo_i);
        if (rst) begin
            e_we   = we;
            e_addr = w_addr;
            e_data = exp_data(aluop, alusel, reg1, reg2, hf, lf);
            if (annul) begin
                e_stall = 0;
            end else if (phase == 0) begin
                e_stall = is_div_op(aluop);
                if (aluop == OP_MTHI) begin e_whilo = 1; e_hi = reg1; e_lo = lf; end
                if (aluop == OP_MTLO) begin e_whilo = 1; e_hi = hf; e_lo = reg1; end
            end else if (phase <= div_len) begin
                e_stall = 1;
            end else begin
                e_whilo = 1; e_hi = mr; e_lo = mq;
            end
        end
        chk("m_we", ex_we, e_we);
        chk("m_waddr", ex_w_addr, e_addr);
        chk("m_wdata", ex_w_data, e_data);
        chk("m_whilo", ex_whilo, e_whilo);
        chk("m_hi", ex_hi, e_hi);
        chk("m_lo", ex_lo, e_lo);
        chk("m_stall", stall_req, e_stall);
    end

    task automatic apply(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        aluop = op; alusel = sel; reg1 = a; reg2 = b;
    endtask

    // Counts stall cycles (bounded), then checks the HI/LO write on the result cycle
    task automatic wait_div(input string name, input int exp_n,
                            input logic [31:0] e_hi, input logic [31:0] e_lo);
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall_req) break;
            n++;
        end
        chk({name, "_stall_cycles"}, n, exp_n);
        chk({name, "_whilo"}, ex_whilo, 1'b1);
        chk({name, "_hi"}, ex_hi, e_hi);
        chk({name, "_lo"}, ex_lo, e_lo);
        apply(OP_NOP, SEL_NOP, 32'd0, 32'd0);
    endtask

    task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_n,
                           input logic [31:0] e_hi, input logic [31:0] e_lo);
        apply(op, SEL_NOP, a, b);
        wait_div(name, exp_n, e_hi, e_lo);
    endtask

    logic [7:0]  t_op [7] = '{OP_AND, OP_XOR, OP_NOR, OP_SLL, OP_MOVN, OP_MFLO, OP_OR};
    logic [2:0]  t_sel[7] = '{SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_SHIFT, SEL_MOVE, SEL_MOVE, SEL_NOP};

    initial begin
        @(negedge clk);
        chk("rst_we", ex_we, 1'b0);
        chk("rst_wdata", ex_w_data, 32'd0);
        chk("rst_waddr", ex_w_addr, 5'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        apply(OP_OR, SEL_LOGIC, 32'h0000_FF00, 32'h00F0_F0F0);
        @(negedge clk);
        chk("or_data", ex_w_data, 32'h00F0_FFF0);
        chk("or_we", ex_we, 1'b1);
        chk("or_waddr", ex_w_addr, 5'd5);
        chk("or_stall", stall_req, 1'b0);

        apply(OP_SRA, SEL_SHIFT, 32'd4, 32'h8000_0000);
        @(negedge clk);
        chk("sra", ex_w_data, 32'hF800_0000);
        apply(OP_SRL, SEL_SHIFT, 32'd4, 32'h8000_0000);
        @(negedge clk);
        chk("srl", ex_w_data, 32'h0800_0000);

        for (int i = 0; i < 7; i++) begin
            we = i[0];
            w_addr = 5'(i + 10);
            apply(t_op[i], t_sel[i], 32'h0F0F_3C03 + 32'(i), 32'hF3C0_5A5A);
        end
        we = 1'b1;
        w_addr = 5'd5;

        mem_whilo = 1'b1; mem_hi = 32'h0000_1234; mem_lo = 32'h0000_4321;
        wb_whilo = 1'b1;  wb_hi = 32'h0000_5678;  wb_lo = 32'h0000_8765;
        apply(OP_MFHI, SEL_MOVE, 32'd0, 32'd0);
        @(negedge clk);
        chk("mfhi_mem", ex_w_data, 32'h0000_1234);
        #1 mem_whilo = 1'b0;
        #1 chk("mfhi_wb", ex_w_data, 32'h0000_5678);
        wb_whilo = 1'b0;
        #1 chk("mfhi_arch", ex_w_data, 32'h0000_AAAA);

        wb_whilo = 1'b1;
        apply(OP_MTHI, SEL_NOP, 32'h0000_CAFE, 32'd0);
        @(negedge clk);
        chk("mthi_whilo", ex_whilo, 1'b1);
        chk("mthi_hi", ex_hi, 32'h0000_CAFE);
        chk("mthi_lo", ex_lo, 32'h0000_8765);
        apply(OP_MTLO, SEL_NOP, 32'h0000_BEEF, 32'd0);
        @(negedge clk);
        chk("mtlo_hi", ex_hi, 32'h0000_5678);
        chk("mtlo_lo", ex_lo, 32'h0000_BEEF);
        wb_whilo = 1'b0;

        run_div("divu_max", OP_DIVU, 32'hFFFF_FFFF, 32'd2, 33, 32'd1, 32'h7FFF_FFFF);
        run_div("div_neg7", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
        run_div("div_zero", OP_DIV, 32'd5, 32'd0, 2, 32'd0, 32'd0);
        run_div("divu_neg", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 33, 32'd1, 32'h7FFF_FFFC);

        apply(OP_DIV, SEL_NOP, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(negedge clk);
        chk("annul_stall", stall_req, 1'b0);
        chk("annul_whilo", ex_whilo, 1'b0);
        @(posedge clk);
        #1 annul = 1'b0;
        wait_div("after_annul", 33, 32'd2, 32'd14);

        apply(OP_DIV, SEL_NOP, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_stall", stall_req, 1'b0);
        chk("midrst_we", ex_we, 1'b0);
        chk("midrst_whilo", ex_whilo, 1'b0);
        chk("midrst_lo", ex_lo, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        wait_div("after_rst", 33, 32'd1, 32'd333);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
